// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer driving the CP0 register-file write port.
// Define EXC_CAUSE_WR_EN to add a Cause write (ExcCode/BD) to the exception sequence.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter logic [4:0]  STATUS_ADDR = 5'd12,
  parameter logic [4:0]  CAUSE_ADDR  = 5'd13,
  parameter logic [4:0]  EPC_ADDR    = 5'd14
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_in_delay_i,
  input  logic [4:0]  ex_excode_i,
  input  logic        ex_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        timer_int_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        pc_redirect_o,
  output logic [31:0] new_pc_o,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic [4:0]  exc_code_o,
  output logic        exc_bd_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_EPC,
`ifdef EXC_CAUSE_WR_EN
    S_WR_CAUSE,
`endif
    S_WR_STATUS,
    S_REDIRECT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_epc;
  logic [31:0] r_status;
  logic [31:0] r_target;
  logic [4:0]  r_code;
  logic        r_bd;

  logic [7:0]  w_ip;
  logic        w_int_pend;
  logic        w_accept;
  logic        w_take_exc;
  logic        w_take_eret;
  logic [4:0]  w_code;

  // Timer interrupt is folded into IP7 before masking with Status.IM.
  assign w_ip        = {cp0_cause_i[15:11] | {timer_int_i, 4'b0}, cp0_cause_i[10:8]};
  assign w_int_pend  = cp0_status_i[0] & ~cp0_status_i[1] & (|(w_ip & cp0_status_i[15:8]));
  assign w_accept    = (r_state == S_IDLE) & ex_valid_i;
  assign w_take_exc  = w_accept & (w_int_pend | (ex_excode_i != 5'd0));
  assign w_take_eret = w_accept & ~w_take_exc & ex_eret_i;
  assign w_code      = w_int_pend ? 5'd0 : ex_excode_i;

`ifndef EXC_CAUSE_WR_EN
  logic w_unused_cause;
  assign w_unused_cause = ^{cp0_cause_i[31:16], cp0_cause_i[7:0]};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latched sequence data; ERET leaves EPC and the reported code untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_epc    <= 32'd0;
      r_status <= 32'd0;
      r_target <= 32'd0;
      r_code   <= 5'd0;
      r_bd     <= 1'b0;
    end else if (w_take_exc) begin
      r_epc    <= ex_in_delay_i ? (ex_pc_i - 32'd4) : ex_pc_i;
      r_status <= cp0_status_i | 32'h2;
      r_target <= EXC_VECTOR;
      r_code   <= w_code;
      r_bd     <= ex_in_delay_i;
    end else if (w_take_eret) begin
      r_status <= cp0_status_i & ~32'h2;
      r_target <= cp0_epc_i;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take_exc) begin
          w_next = S_WR_EPC;
        end else if (w_take_eret) begin
          w_next = S_WR_STATUS;
        end
      end
`ifdef EXC_CAUSE_WR_EN
      S_WR_EPC:    w_next = S_WR_CAUSE;
      S_WR_CAUSE:  w_next = S_WR_STATUS;
`else
      S_WR_EPC:    w_next = S_WR_STATUS;
`endif
      S_WR_STATUS: w_next = S_REDIRECT;
      S_REDIRECT:  w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o       = (r_state != S_IDLE);
    flush_o       = 1'b0;
    pc_redirect_o = 1'b0;
    new_pc_o      = 32'd0;
    cp0_we_o      = 1'b0;
    cp0_waddr_o   = 5'd0;
    cp0_wdata_o   = 32'd0;
    case (r_state)
      S_WR_EPC: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = EPC_ADDR;
        cp0_wdata_o = r_epc;
      end
`ifdef EXC_CAUSE_WR_EN
      S_WR_CAUSE: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = CAUSE_ADDR;
        cp0_wdata_o = {r_bd, cp0_cause_i[30:7], r_code, cp0_cause_i[1:0]};
      end
`endif
      S_WR_STATUS: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = STATUS_ADDR;
        cp0_wdata_o = r_status;
      end
      S_REDIRECT: begin
        flush_o       = 1'b1;
        pc_redirect_o = 1'b1;
        new_pc_o      = r_target;
      end
      default: ;
    endcase
  end

  assign exc_code_o = r_code;
  assign exc_bd_o   = r_bd;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed cases then random events against a CP0 behavioural model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_in_delay_i;
  logic [4:0]  ex_excode_i;
  logic        ex_eret_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        timer_int_i;
  logic        stall_o;
  logic        flush_o;
  logic        pc_redirect_o;
  logic [31:0] new_pc_o;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic [4:0]  exc_code_o;
  logic        exc_bd_o;

  exc_ctrl dut (
    .clk(clk), .resetn(resetn),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_in_delay_i(ex_in_delay_i),
    .ex_excode_i(ex_excode_i), .ex_eret_i(ex_eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .timer_int_i(timer_int_i),
    .stall_o(stall_o), .flush_o(flush_o), .pc_redirect_o(pc_redirect_o), .new_pc_o(new_pc_o),
    .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
    .exc_code_o(exc_code_o), .exc_bd_o(exc_bd_o)
  );

  always #5 clk = ~clk;

  // Behavioural CP0: registers that the bench drives and that absorb the expected writes.
  logic [31:0] mStatus, mCause, mEpc;
  assign cp0_status_i = mStatus;
  assign cp0_cause_i  = mCause;
  assign cp0_epc_i    = mEpc;

  typedef struct {
    bit        we;
    bit [4:0]  addr;
    bit [31:0] data;
    bit        isCause;
    bit        redir;
    bit [31:0] pc;
  } step_t;

  step_t    expQ[$];
  step_t    cur;
  bit       busy;
  bit [4:0] expCode;
  bit       expBd;
  int       checks;
  int       failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic pushStep(input bit we, input bit [4:0] addr, input bit [31:0] data,
                          input bit isCause, input bit redir, input bit [31:0] pc);
    step_t s;
    s.we = we; s.addr = addr; s.data = data; s.isCause = isCause; s.redir = redir; s.pc = pc;
    expQ.push_back(s);
  endtask

  // Decide what the current inputs mean and queue the expected per-cycle outputs.
  task automatic modelAccept();
    bit [7:0] ip;
    bit       pend;
    ip   = mCause[15:8] | (timer_int_i ? 8'h80 : 8'h00);
    pend = mStatus[0] && !mStatus[1] && ((ip & mStatus[15:8]) != 8'h00);
    if (pend || ex_excode_i != 5'd0) begin
      expCode = pend ? 5'd0 : ex_excode_i;
      expBd   = ex_in_delay_i;
      pushStep(1, 5'd14, ex_in_delay_i ? ex_pc_i - 32'd4 : ex_pc_i, 0, 0, 0);
`ifdef EXC_CAUSE_WR_EN
      pushStep(1, 5'd13, 32'd0, 1, 0, 0);
`endif
      pushStep(1, 5'd12, mStatus | 32'h2, 0, 0, 0);
      pushStep(0, 5'd0, 32'd0, 0, 1, 32'hBFC00380);
    end else if (ex_eret_i) begin
      pushStep(1, 5'd12, mStatus & ~32'h2, 0, 0, 0);
      pushStep(0, 5'd0, 32'd0, 0, 1, mEpc);
    end
  endtask

  task automatic checkOutput();
    bit we;
    bit redir;
    if (busy && cur.isCause) begin
      cur.data      = mCause;
      cur.data[31]  = expBd;
      cur.data[6:2] = expCode;
    end
    we    = busy && cur.we;
    redir = busy && cur.redir;
    check("stall",    32'(stall_o),       32'(busy));
    check("cp0_we",   32'(cp0_we_o),      32'(we));
    check("waddr",    32'(cp0_waddr_o),   we ? 32'(cur.addr) : 32'd0);
    check("wdata",    cp0_wdata_o,        we ? cur.data : 32'd0);
    check("flush",    32'(flush_o),       32'(redir));
    check("redirect", 32'(pc_redirect_o), 32'(redir));
    check("new_pc",   new_pc_o,           redir ? cur.pc : 32'd0);
    check("exc_code", 32'(exc_code_o),    32'(expCode));
    check("exc_bd",   32'(exc_bd_o),      32'(expBd));
  endtask

  // One clock: accept in model if idle, advance, commit CP0 writes, check outputs.
  task automatic applyStimulus();
    if (!busy && ex_valid_i) modelAccept();
    @(posedge clk);
    #1;
    if (busy && cur.we) begin
      case (cur.addr)
        5'd14:   mEpc    = cur.data;
        5'd13:   mCause  = cur.data;
        default: mStatus = cur.data;
      endcase
    end
    busy = (expQ.size() > 0);
    if (busy) cur = expQ.pop_front();
    checkOutput();
  endtask

  task automatic clearEvent();
    ex_valid_i = 0; ex_excode_i = 0; ex_eret_i = 0; ex_in_delay_i = 0; ex_pc_i = 0;
  endtask

  task automatic drain();
    clearEvent();
    for (int i = 0; i < 8; i++) applyStimulus();
  endtask

  task automatic applyReset();
    clearEvent();
    resetn = 0;
    #1;
    expQ.delete();
    busy = 0; expCode = 0; expBd = 0;
    checkOutput();
    @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    checks = 0; failures = 0; busy = 0; expCode = 0; expBd = 0;
    mStatus = 0; mCause = 0; mEpc = 0; timer_int_i = 0;
    clearEvent();
    applyReset();
    applyStimulus();

    // Syscall from a normal slot.
    mStatus = 32'h10000001;
    ex_valid_i = 1; ex_pc_i = 32'h80001000; ex_excode_i = 5'd8;
    applyStimulus();
    check("sys_epc_addr", 32'(cp0_waddr_o), 32'd14);
    check("sys_epc_data", cp0_wdata_o, 32'h80001000);
    clearEvent();
`ifdef EXC_CAUSE_WR_EN
    applyStimulus();
`endif
    applyStimulus();
    check("sys_status", cp0_wdata_o, 32'h10000003);
    applyStimulus();
    check("sys_vector", new_pc_o, 32'hBFC00380);
    check("sys_code", 32'(exc_code_o), 32'd8);
    drain();

    // Overflow in a delay slot.
    mStatus = 32'h10000001;
    ex_valid_i = 1; ex_pc_i = 32'h80002004; ex_in_delay_i = 1; ex_excode_i = 5'd12;
    applyStimulus();
    check("ov_epc", cp0_wdata_o, 32'h80002000);
    check("ov_bd", 32'(exc_bd_o), 32'd1);
    drain();

    // ERET: Status then redirect to EPC.
    mStatus = 32'h10000003; mEpc = 32'h80003000;
    ex_valid_i = 1; ex_eret_i = 1;
    applyStimulus();
    check("eret_addr", 32'(cp0_waddr_o), 32'd12);
    check("eret_status", cp0_wdata_o, 32'h10000001);
    clearEvent();
    applyStimulus();
    check("eret_pc", new_pc_o, 32'h80003000);
    drain();

    // Timer interrupt outranks a concurrent syscall, unless EXL masks it.
    mStatus = 32'h10008001; timer_int_i = 1;
    ex_valid_i = 1; ex_pc_i = 32'h80004000; ex_excode_i = 5'd8;
    applyStimulus();
    check("int_code", 32'(exc_code_o), 32'd0);
    drain();
    mStatus = 32'h10008003;
    ex_valid_i = 1; ex_pc_i = 32'h80004000; ex_excode_i = 5'd8;
    applyStimulus();
    check("exl_code", 32'(exc_code_o), 32'd8);
    drain();
    timer_int_i = 0;

    // Reset while writing Status.
    mStatus = 32'h10000001;
    ex_valid_i = 1; ex_pc_i = 32'h80005000; ex_excode_i = 5'd8;
    applyStimulus();
    clearEvent();
`ifdef EXC_CAUSE_WR_EN
    applyStimulus();
`endif
    applyStimulus();
    applyReset();
    check("rst_we", 32'(cp0_we_o), 32'd0);
    applyStimulus();
    applyStimulus();

    // PC wrap-around for a delay-slot EPC.
    mStatus = 32'h10000001;
    ex_valid_i = 1; ex_pc_i = 32'h00000000; ex_in_delay_i = 1; ex_excode_i = 5'd10;
    applyStimulus();
    check("wrap_epc", cp0_wdata_o, 32'hFFFFFFFC);
    drain();

    // Random events, including back-to-back and ignored-while-busy inputs.
    for (int n = 0; n < 600; n++) begin
      if (!busy) begin
        mStatus = $urandom;
        mEpc    = $urandom;
      end
      mCause        = $urandom;
      timer_int_i   = ($urandom_range(0, 3) == 0);
      ex_valid_i    = ($urandom_range(0, 3) != 0);
      ex_pc_i       = $urandom;
      ex_in_delay_i = $urandom_range(0, 1) != 0;
      ex_excode_i   = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ex_eret_i     = $urandom_range(0, 1) != 0;
      applyStimulus();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
